// File: rtl/svc_rv_ifetch.sv
// svc_fifo: small in-order FIFO with synchronous flush, head shown combinationally.
// Latency: a pushed entry is visible at head_dat the cycle after the push.
// Backpressure: none internal; the owner must not push a full FIFO unless it pops in the same cycle.
// Ports: push/push_dat write an entry, pop retires the head, flush empties, count is occupancy.
module svc_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [W-1:0]                 push_dat,
    input  logic                         pop,
    output logic [W-1:0]                 head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign head_dat = mem[rd_ptr];
    assign count    = count_q;

    assert property (@(posedge clk) disable iff (rst || flush)
        (push && !pop) |-> (count_q != CW'(DEPTH)));
    assert property (@(posedge clk) disable iff (rst || flush)
        pop |-> (count_q != '0));
endmodule

// svc_rv_ifetch: PC generation, imem request issue and 2-entry instruction buffer for IF/ID.
// Latency: request in cycle N, 1-cycle memory response in N+1, valid_if in N+2; 1 instr/cycle steady.
// Backpressure: stall holds the head; credits (outstanding+discard+buffered <= 2) stop issue, never responses.
// Ports: clk/rst; stall, redirect_valid/redirect_pc from the pipeline; imem_req_* / imem_rsp_* to
// instruction memory; valid_if, pc_if, pc_plus4_if, instr_if to the IF/ID register (zero when invalid).
module svc_rv_ifetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            valid_if,
    output logic [XLEN-1:0] pc_if,
    output logic [XLEN-1:0] pc_plus4_if,
    output logic [31:0]     instr_if
);
    logic [XLEN-1:0]    fetch_pc;
    logic [1:0]         discard;
    logic [1:0]         outstanding;
    logic [1:0]         fifo_count;
    logic [XLEN-1:0]    pcq_head;
    logic [XLEN+31:0]   head;
    logic               pop;
    logic               req_fire;
    logic               rsp_live;
    logic               rsp_push;
    logic [2:0]         credits_used;

    assign pop          = valid_if && !stall && !redirect_valid;
    assign credits_used = 3'(outstanding) + 3'(discard) + 3'(fifo_count) - 3'(pop);

    assign imem_req_valid = !rst && !redirect_valid && (credits_used < 3'd2);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Stale responses always come first (in-order memory), so a response is live
    // exactly when no discard credit is pending. A live response landing in a
    // redirect cycle still retires its request but is not buffered.
    assign rsp_live = imem_rsp_valid && (discard == 2'd0);
    assign rsp_push = rsp_live && !redirect_valid;

    // The pc queue occupancy doubles as the outstanding-request count: it grows
    // on every accepted request, shrinks on every live response, and is flushed
    // (outstanding -> 0) on redirect.
    svc_fifo #(.W(XLEN), .DEPTH(2)) u_pcq (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push     (req_fire),
        .push_dat (fetch_pc),
        .pop      (rsp_live),
        .head_dat (pcq_head),
        .count    (outstanding)
    );

    svc_fifo #(.W(XLEN + 32), .DEPTH(2)) u_ibuf (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push     (rsp_push),
        .push_dat ({pcq_head, imem_rsp_data}),
        .pop      (pop),
        .head_dat (head),
        .count    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            discard  <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~XLEN'(3);
            // Every response this cycle retires one stale or one outstanding
            // request; whatever remains in flight becomes stale.
            discard  <= discard + outstanding - 2'(imem_rsp_valid);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
            if (imem_rsp_valid && discard != 2'd0) discard <= discard - 2'd1;
        end
    end

    assign valid_if    = fifo_count != 2'd0;
    assign pc_if       = valid_if ? head[XLEN+31:32] : '0;
    assign instr_if    = valid_if ? head[31:0] : '0;
    assign pc_plus4_if = valid_if ? pc_if + XLEN'(4) : '0;

    assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (outstanding != 2'd0 || discard != 2'd0));
    assert property (@(posedge clk) disable iff (rst)
        (3'(outstanding) + 3'(discard) + 3'(fifo_count)) <= 3'd2);
endmodule

// File: tb/tb_svc_rv_ifetch.sv
module tb_svc_rv_ifetch;
    localparam logic [31:0] RST_PC = 32'h100;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        valid_if;
    logic [31:0] pc_if;
    logic [31:0] pc_plus4_if;
    logic [31:0] instr_if;

    always #5 clk = ~clk;

    svc_rv_ifetch #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .valid_if       (valid_if),
        .pc_if          (pc_if),
        .pc_plus4_if    (pc_plus4_if),
        .instr_if       (instr_if)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: memory as a queue of accepted requests with due cycles,
    // the fetch stream as "next PC the pipeline should see" and "next PC that
    // should be requested", plus a count of buffered good instructions.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;
    req_t        mem_q[$];
    int          last_due   = 0;
    int          stale_left = 0;
    int          tb_fifo    = 0;
    int          lat_fix    = 1;
    logic [31:0] exp_pc     = RST_PC;
    logic [31:0] exp_req    = RST_PC;

    logic        s_rst, s_redir, s_rsp, s_fire, s_pop;
    logic [31:0] s_rpc, s_addr;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called just after a falling edge with the pipeline inputs already set.
    task automatic pre_edge();
        logic ev;
        int   erv;
        if (!rst && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = tag(mem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #4;
        s_rst   = rst;
        s_redir = redirect_valid;
        s_rpc   = redirect_pc;
        s_rsp   = imem_rsp_valid;
        s_fire  = imem_req_valid && imem_req_ready;
        s_addr  = imem_req_addr;
        s_pop   = (tb_fifo != 0) && !stall && !redirect_valid;
        if (rst) begin
            chk("req_valid_in_reset", 32'(imem_req_valid), 32'd0);
        end else begin
            ev = (tb_fifo != 0);
            chk("valid_if", 32'(valid_if), 32'(ev));
            chk("pc_if", pc_if, ev ? exp_pc : 32'd0);
            chk("pc_plus4_if", pc_plus4_if, ev ? exp_pc + 32'd4 : 32'd0);
            chk("instr_if", instr_if, ev ? tag(exp_pc) : 32'd0);
            erv = (!redirect_valid && (mem_q.size() + tb_fifo - (s_pop ? 1 : 0) < 2)) ? 1 : 0;
            chk("imem_req_valid", 32'(imem_req_valid), 32'(erv));
            if (imem_req_valid) chk("imem_req_addr", imem_req_addr, exp_req);
        end
    endtask

    task automatic post_edge();
        int   lat;
        int   due;
        int   cyc_old;
        req_t r;
        @(posedge clk);
        cyc_old = cyc;
        cyc++;
        if (s_rst) begin
            mem_q.delete();
            stale_left = 0;
            tb_fifo    = 0;
            exp_pc     = RST_PC;
            exp_req    = RST_PC;
            last_due   = 0;
        end else begin
            if (s_rsp) begin
                r = mem_q.pop_front();
                if (stale_left > 0) stale_left--;
                else if (!s_redir) tb_fifo++;
            end
            if (s_redir) begin
                stale_left = mem_q.size();
                tb_fifo    = 0;
                exp_pc     = {s_rpc[31:2], 2'b00};
                exp_req    = exp_pc;
            end else begin
                if (s_pop) begin
                    exp_pc = exp_pc + 32'd4;
                    tb_fifo--;
                end
                if (s_fire) begin
                    lat = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 4));
                    due = cyc_old + lat;
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    r.addr = s_addr;
                    r.due  = due;
                    mem_q.push_back(r);
                    exp_req = exp_req + 32'd4;
                end
            end
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        v;
        logic [31:0] pc;
        logic        rv;
        logic [31:0] ra;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic r, input logic s, input logic d, input logic [31:0] rpc,
                                input logic v, input logic [31:0] pc, input logic rv,
                                input logic [31:0] ra);
        vec_t t;
        t.rst = r; t.stall = s; t.redir = d; t.rpc = rpc;
        t.v = v; t.pc = pc; t.rv = rv; t.ra = ra;
        tbl.push_back(t);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int found;

        // Per-cycle expectations with 1-cycle memory and ready=1, starting at
        // the first cycle after reset is released.
        add(1, 0, 0, 0, 0, 0, 0, 32'h100);                 // reset state
        add(0, 0, 0, 0, 0, 0, 1, 32'h100);                 // first request
        add(0, 0, 0, 0, 0, 0, 1, 32'h104);
        for (int c = 2; c <= 3; c++) add(0, 0, 0, 0, 1, 32'(32'h100 + 4 * (c - 2)), 1, 32'(32'h100 + 4 * c));
        for (int c = 4; c <= 8; c++) add(0, 1, 0, 0, 1, 32'h108, 0, 32'h110);   // stall, fills to 2
        for (int c = 9; c <= 12; c++) add(0, 0, 0, 0, 1, 32'(32'h100 + 4 * (c - 7)), 1, 32'(32'h100 + 4 * (c - 5)));
        add(0, 1, 0, 0, 1, 32'h118, 0, 32'h120);
        add(0, 1, 0, 0, 1, 32'h118, 0, 32'h120);
        add(0, 1, 1, 32'h2003, 1, 32'h118, 0, 32'h120);    // redirect over stall, full buffer
        add(0, 0, 0, 0, 0, 0, 1, 32'h2000);
        add(0, 0, 0, 0, 0, 0, 1, 32'h2004);
        add(0, 0, 0, 0, 1, 32'h2000, 1, 32'h2008);
        add(0, 0, 0, 0, 1, 32'h2004, 1, 32'h200C);
        add(0, 0, 1, 32'hFFFF_FFFA, 1, 32'h2008, 0, 32'h2010);  // redirect with response landing
        add(0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFF8);
        add(0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        add(0, 0, 0, 0, 1, 32'hFFFF_FFF8, 1, 32'h0);       // address wraps
        add(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'h4);       // pc_plus4 wraps to 0
        add(0, 0, 0, 0, 1, 32'h0, 1, 32'h8);
        add(1, 0, 0, 0, 1, 32'h4, 0, 32'hC);               // reset mid-stream
        add(0, 0, 0, 0, 0, 0, 1, 32'h100);
        add(0, 0, 0, 0, 0, 0, 1, 32'h104);
        add(0, 0, 0, 0, 1, 32'h100, 1, 32'h108);

        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        for (int i = 0; i < 2; i++) begin pre_edge(); post_edge(); end

        lat_fix = 1;
        foreach (tbl[i]) begin
            rst            = tbl[i].rst;
            stall          = tbl[i].stall;
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].rpc;
            imem_req_ready = 1'b1;
            pre_edge();
            chk($sformatf("tbl%0d_valid_if", i), 32'(valid_if), 32'(tbl[i].v));
            chk($sformatf("tbl%0d_pc_if", i), pc_if, tbl[i].v ? tbl[i].pc : 32'd0);
            chk($sformatf("tbl%0d_pc_plus4_if", i), pc_plus4_if, tbl[i].v ? tbl[i].pc + 32'd4 : 32'd0);
            chk($sformatf("tbl%0d_instr_if", i), instr_if, tbl[i].v ? tag(tbl[i].pc) : 32'd0);
            chk($sformatf("tbl%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].rv));
            chk($sformatf("tbl%0d_req_addr", i), imem_req_addr, tbl[i].ra);
            post_edge();
        end

        // Redirect with two requests in flight on a 3-cycle memory: both stale
        // responses hold their credits until dropped, so the first new
        // instruction appears 6 cycles after the redirect.
        lat_fix = 3;
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b1;
        pre_edge(); post_edge();
        rst = 1'b0;
        pre_edge(); post_edge();
        pre_edge(); post_edge();
        redirect_valid = 1'b1; redirect_pc = 32'h3000;
        pre_edge(); post_edge();
        redirect_valid = 1'b0;
        found = 0;
        for (int k = 1; k <= 20; k++) begin
            pre_edge();
            if (valid_if && found == 0) begin
                found = k;
                chk("discard_first_pc", pc_if, 32'h3000);
            end
            post_edge();
        end
        chk("discard_first_valid_cycle", 32'(found), 32'd6);

        // Randomized traffic: ready, stall, latency, redirect and reset.
        lat_fix = 0;
        rst = 1'b1;
        pre_edge(); post_edge();
        for (int n = 0; n < 4000; n++) begin
            rst            = ($urandom_range(0, 399) == 0);
            stall          = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : 32'($urandom);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            pre_edge();
            post_edge();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
